// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Byte enables for an access of the given width at the given word offset.
  function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] addr);
    logic [3:0] be;
    case (funct3)
      F3_B, F3_BU: be = 4'b0001 << addr;
      F3_H, F3_HU: be = addr[1] ? 4'b1100 : 4'b0011;
      F3_W:        be = 4'b1111;
      default:     be = 4'b0000;
    endcase
    return be;
  endfunction

  // Encodings with no meaning: reserved funct3 values, and unsigned stores.
  function automatic logic is_illegal(input logic [2:0] funct3, input logic we);
    logic bad;
    case (funct3)
      F3_B, F3_H, F3_W: bad = 1'b0;
      F3_BU, F3_HU:     bad = we;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering between the core and the word bus.
// load=0: replicate store data across lanes. load=1: extract and extend load data.
// misalign reports an access whose width does not divide the byte offset.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        load,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  output logic [31:0] aligned,
  output logic        misalign
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Pick the addressed byte lane of the bus word.
  always_comb begin
    case (addr)
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
  end

  assign lane_h = addr[1] ? word[31:16] : word[15:0];

  // Width-dependent replication / extension and alignment check.
  always_comb begin
    aligned  = '0;
    misalign = 1'b0;
    case (funct3)
      F3_B:  aligned = load ? {{24{lane_b[7]}}, lane_b} : {4{word[7:0]}};
      F3_BU: aligned = load ? {24'b0, lane_b} : {4{word[7:0]}};
      F3_H: begin
        misalign = addr[0];
        aligned  = load ? {{16{lane_h[15]}}, lane_h} : {2{word[15:0]}};
      end
      F3_HU: begin
        misalign = addr[0];
        aligned  = load ? {16'b0, lane_h} : {2{word[15:0]}};
      end
      F3_W: begin
        misalign = (addr != 2'd0);
        aligned  = word;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one core load/store becomes one byte-enabled word bus access.
// Optional bus timeout is compiled in with `define LSU_TIMEOUT_EN.
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  input  logic            we_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] rdata_o,
  output logic            stall_o,
  output logic            done_o,
  output logic            err_o,
  output logic            bus_req_o,
  output logic            bus_we_o,
  output logic [3:0]      bus_be_o,
  output logic [XLEN-1:0] bus_addr_o,
  output logic [XLEN-1:0] bus_wdata_o,
  input  logic            bus_ack_i,
  input  logic [XLEN-1:0] bus_rdata_i
);

  state_t state, state_d;

  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic            bus_req_d, bus_we_d, done_d, err_d;
  logic [3:0]      bus_be_d;
  logic [XLEN-1:0] bus_addr_d, bus_wdata_d, rdata_d;

  logic            al_load, al_mis;
  logic [2:0]      al_f3;
  logic [1:0]      al_off;
  logic [31:0]     al_word, al_out;
  logic            bad, timeout;

  // One aligner serves both directions: store data while idle, load data while busy.
  assign al_load = (state == BUSY);
  assign al_f3   = al_load ? f3_q : funct3_i;
  assign al_off  = al_load ? off_q : addr_i[1:0];
  assign al_word = al_load ? bus_rdata_i : wdata_i;

  lsu_align u_align (
    .load     (al_load),
    .funct3   (al_f3),
    .addr     (al_off),
    .word     (al_word),
    .aligned  (al_out),
    .misalign (al_mis)
  );

  assign bad = is_illegal(funct3_i, we_i) | al_mis;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;

  // Busy-cycle counter, zero whenever the FSM is outside BUSY.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)              cnt <= '0;
    else if (state != BUSY)  cnt <= '0;
    else                     cnt <= cnt + 1'b1;
  end

  assign timeout = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state logic; an ack on the timeout cycle still completes normally.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (req_i) state_d = bad ? DONE : BUSY;
      BUSY:    if (bus_ack_i || timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    bus_req_d   = bus_req_o;
    bus_we_d    = bus_we_o;
    bus_be_d    = bus_be_o;
    bus_addr_d  = bus_addr_o;
    bus_wdata_d = bus_wdata_o;
    f3_d        = f3_q;
    off_d       = off_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    rdata_d     = '0;
    case (state)
      IDLE: begin
        if (req_i) begin
          if (bad) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            bus_req_d   = 1'b1;
            bus_we_d    = we_i;
            bus_be_d    = be_gen(funct3_i, addr_i[1:0]);
            bus_addr_d  = {addr_i[XLEN-1:2], 2'b00};
            bus_wdata_d = al_out;
            f3_d        = funct3_i;
            off_d       = addr_i[1:0];
          end
        end
      end
      BUSY: begin
        if (bus_ack_i) begin
          bus_req_d = 1'b0;
          done_d    = 1'b1;
          if (!bus_we_o) rdata_d = al_out;
        end else if (timeout) begin
          bus_req_d = 1'b0;
          done_d    = 1'b1;
          err_d     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output and access-context registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_be_o    <= 4'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      f3_q        <= 3'b0;
      off_q       <= 2'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      rdata_o     <= '0;
    end else begin
      bus_req_o   <= bus_req_d;
      bus_we_o    <= bus_we_d;
      bus_be_o    <= bus_be_d;
      bus_addr_o  <= bus_addr_d;
      bus_wdata_o <= bus_wdata_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      done_o      <= done_d;
      err_o       <= err_d;
      rdata_o     <= rdata_d;
    end
  end

  // Held low during reset so every output reads 0 while rst_i is asserted.
  assign stall_o = rst_i & req_i & ~done_o;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu with a transaction-level reference model.
`timescale 1ns/1ps
module tb_lsu;

  localparam int TMO = 8;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [2:0]  funct3_i = 3'd0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;
  logic        stall_o, done_o, err_o, bus_req_o, bus_we_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic        bus_ack_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;

  always #5 clk_i = ~clk_i;

  lsu #(.XLEN(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .stall_o(stall_o),
    .done_o(done_o), .err_o(err_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_be_o(bus_be_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit m_illegal(input logic we, input logic [2:0] f3);
    return (f3 == 3'd3) || (f3 > 3'd5) || (we && f3 > 3'd3);
  endfunction

  function automatic bit m_mis(input logic [2:0] f3, input logic [31:0] addr);
    return (int'(addr[1:0]) % m_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
    logic [7:0] m;
    m = 8'(((1 << m_size(f3)) - 1) << addr[1:0]);
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wrep(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int s;
    s = m_size(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % s) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] rd);
    logic [31:0] v, mask;
    int s;
    s = m_size(f3);
    v = rd >> (8 * int'(addr[1:0]));
    mask = (s == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * s)) - 32'd1);
    v = v & mask;
    if (f3 < 3'd4 && s < 4 && v[8*s-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- expectations and observations ----------------
  logic        chk_en = 1'b0;
  logic        exp_bus_req = 1'b0, exp_done = 1'b0, exp_err = 1'b0, chk_rd = 1'b0, exp_we = 1'b0;
  logic [3:0]  exp_be = '0;
  logic [31:0] exp_addr = '0, exp_wdata = '0, exp_rdata = '0;
  int          cyc = 0;
  int          start_cyc = -1;

  logic [3:0]  obs_be;
  logic [31:0] obs_addr, obs_wdata, obs_rdata;
  logic        obs_err, obs_req_seen, obs_stall_done;
  int          obs_lat, obs_stall_cnt;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Every-cycle comparison of the DUT against the model's expectations.
  always @(negedge clk_i) begin
    if (chk_en) begin
      check("stall", {31'b0, stall_o}, {31'b0, req_i & ~exp_done});
      check("bus_req", {31'b0, bus_req_o}, {31'b0, exp_bus_req});
      check("done", {31'b0, done_o}, {31'b0, exp_done});
      check("err", {31'b0, err_o}, {31'b0, exp_err});
      if (chk_rd) check("rdata", rdata_o, exp_rdata);
      if (exp_bus_req) begin
        check("bus_we", {31'b0, bus_we_o}, {31'b0, exp_we});
        check("bus_be", {28'b0, bus_be_o}, {28'b0, exp_be});
        check("bus_addr", bus_addr_o, exp_addr);
        if (exp_we) check("bus_wdata", bus_wdata_o, exp_wdata);
      end
      if (cyc == start_cyc) begin
        obs_stall_cnt = 0;
        obs_req_seen = 1'b0;
        obs_lat = -1;
      end
      if (stall_o) obs_stall_cnt++;
      if (bus_req_o) begin
        obs_req_seen = 1'b1;
        obs_be = bus_be_o;
        obs_addr = bus_addr_o;
        obs_wdata = bus_wdata_o;
      end
      if (done_o) begin
        obs_lat = cyc - start_cyc;
        obs_err = err_o;
        obs_rdata = rdata_o;
        obs_stall_done = stall_o;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      req_i = 1'b0;
      funct3_i = 3'($urandom);
      addr_i = $urandom;
      bus_ack_i = 1'($urandom);
      bus_rdata_i = $urandom;
      exp_bus_req = 1'b0; exp_done = 1'b0; exp_err = 1'b0; chk_rd = 1'b0;
    end
  endtask

  // One core access; d = bus cycles before ack (ack in cycle d+1 after the request).
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int d, input bit drop);
    bit bad, tmo;
    int n;
    bad = m_illegal(we, f3) || m_mis(f3, addr);
    tmo = 1'b0;
`ifdef LSU_TIMEOUT_EN
    if (!bad && d > TMO - 1) tmo = 1'b1;
`endif
    step();
    req_i = 1'b1; we_i = we; funct3_i = f3; addr_i = addr; wdata_i = wd;
    bus_ack_i = 1'($urandom); bus_rdata_i = $urandom;
    exp_bus_req = 1'b0; exp_done = 1'b0; exp_err = 1'b0; chk_rd = 1'b0;
    exp_we = we; exp_be = m_be(f3, addr); exp_addr = {addr[31:2], 2'b00};
    exp_wdata = m_wrep(f3, wd);
    start_cyc = cyc;
    if (!bad) begin
      n = tmo ? TMO : d + 1;
      for (int c = 1; c <= n; c++) begin
        step();
        if (drop) req_i = 1'b0;
        exp_bus_req = 1'b1;
        bus_ack_i = (!tmo && c == n);
        bus_rdata_i = bus_ack_i ? rd : $urandom;
      end
    end
    step();
    if (drop) req_i = 1'b0;
    bus_ack_i = 1'($urandom); bus_rdata_i = $urandom;
    exp_bus_req = 1'b0; exp_done = 1'b1; exp_err = bad || tmo;
    chk_rd = bad || tmo || !we;
    exp_rdata = (bad || tmo) ? 32'h0 : m_load(f3, addr, rd);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    req_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_stall", {31'b0, stall_o}, 32'd0);
    check("rst_bus_req", {31'b0, bus_req_o}, 32'd0);
    check("rst_done", {31'b0, done_o}, 32'd0);
    check("rst_err", {31'b0, err_o}, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_be", {28'b0, bus_be_o}, 32'd0);
    check("rst_addr", bus_addr_o, 32'd0);
    req_i = 1'b0;
    rst_i = 1'b1;
    chk_en = 1'b1;

    check("model_lb", m_load(3'd0, 32'h103, 32'h80FF_0000), 32'hFFFF_FF80);
    check("model_lbu", m_load(3'd4, 32'h103, 32'h80FF_0000), 32'h0000_0080);
    check("model_sh_rep", m_wrep(3'd1, 32'h0000_1234), 32'h1234_1234);
    check("model_sh_be", {28'b0, m_be(3'd1, 32'h202)}, 32'h0000_000C);

    // SW, ack in cycle 1
    access(1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
    idle(1);
    check("t1_be", {28'b0, obs_be}, 32'h0000_000F);
    check("t1_addr", obs_addr, 32'h100);
    check("t1_wdata", obs_wdata, 32'hDEAD_BEEF);
    check("t1_lat", obs_lat, 32'd2);
    check("t1_stall_at_done", {31'b0, obs_stall_done}, 32'd0);

    // LB / LBU at byte 3
    access(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_0000, 1, 1'b0);
    idle(1);
    check("t2_be", {28'b0, obs_be}, 32'h0000_0008);
    check("t2_lb", obs_rdata, 32'hFFFF_FF80);
    access(1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF_0000, 0, 1'b0);
    idle(1);
    check("t2_lbu", obs_rdata, 32'h0000_0080);

    // SH upper half, then misaligned LH
    access(1'b1, 3'd1, 32'h202, 32'h0000_1234, 32'h0, 2, 1'b0);
    idle(1);
    check("t3_be", {28'b0, obs_be}, 32'h0000_000C);
    check("t3_wdata", obs_wdata, 32'h1234_1234);
    access(1'b0, 3'd1, 32'h201, 32'h0, 32'h5555_5555, 0, 1'b0);
    idle(1);
    check("t3_err", {31'b0, obs_err}, 32'd1);
    check("t3_no_bus", {31'b0, obs_req_seen}, 32'd0);
    check("t3_lat", obs_lat, 32'd1);

    // LW with ack in cycle 5
    access(1'b0, 3'd2, 32'h3000, 32'h0, 32'hCAFE_F00D, 4, 1'b0);
    idle(1);
    check("t4_stall_cycles", obs_stall_cnt, 32'd6);
    check("t4_rdata", obs_rdata, 32'hCAFE_F00D);
    check("t4_lat", obs_lat, 32'd6);

    // Back-to-back accesses with no idle gap
    access(1'b0, 3'd5, 32'h402, 32'h0, 32'h8001_7FFF, 0, 1'b0);
    access(1'b0, 3'd1, 32'h402, 32'h0, 32'h8001_7FFF, 0, 1'b0);
    idle(1);
    check("t_b2b_lh", obs_rdata, 32'hFFFF_8001);

    // Reset in BUSY
    chk_en = 1'b0;
    step();
    req_i = 1'b1; we_i = 1'b0; funct3_i = 3'd2; addr_i = 32'h40; bus_ack_i = 1'b0;
    step();
    step();
    check("t5_busreq_before", {31'b0, bus_req_o}, 32'd1);
    #2 rst_i = 1'b0;
    #1;
    check("t5_busreq_rst", {31'b0, bus_req_o}, 32'd0);
    check("t5_stall_rst", {31'b0, stall_o}, 32'd0);
    check("t5_done_rst", {31'b0, done_o}, 32'd0);
    step();
    rst_i = 1'b1; req_i = 1'b0;
    step();
    bus_ack_i = 1'b1; bus_rdata_i = 32'h1234;
    for (int k = 0; k < 3; k++) begin
      step();
      bus_ack_i = 1'b0;
      #3;
      check("t5_busreq_after", {31'b0, bus_req_o}, 32'd0);
      check("t5_done_after", {31'b0, done_o}, 32'd0);
    end
    exp_bus_req = 1'b0; exp_done = 1'b0; exp_err = 1'b0; chk_rd = 1'b0;
    step();
    chk_en = 1'b1;

    // Long wait for ack
    access(1'b0, 3'd2, 32'h500, 32'h0, 32'h1357_9BDF, 40, 1'b0);
    idle(1);
`ifdef LSU_TIMEOUT_EN
    check("t6_lat", obs_lat, TMO + 1);
    check("t6_err", {31'b0, obs_err}, 32'd1);
    check("t6_rdata", obs_rdata, 32'd0);
    access(1'b0, 3'd2, 32'h504, 32'h0, 32'h2468_ACE0, TMO - 1, 1'b0);
    idle(1);
    check("t6_ack_wins_err", {31'b0, obs_err}, 32'd0);
    check("t6_ack_wins_rdata", obs_rdata, 32'h2468_ACE0);
`else
    check("t6_lat", obs_lat, 32'd42);
    check("t6_stall_cycles", obs_stall_cnt, 32'd42);
    check("t6_err", {31'b0, obs_err}, 32'd0);
`endif

    // Randomized accesses
    for (int n = 0; n < 300; n++) begin
      access(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
             int'($urandom_range(0, 6)), ($urandom_range(0, 7) == 0));
      idle(int'($urandom_range(0, 2)));
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
